// File: rtl/taillamp_pkg.sv
// taillamp_pkg
// Shared definitions for the tail-lamp input conditioning block:
//   - FSM state type and encodings (IDLE / ARMING / RUN)
//   - side_mode encodings (SIDE_BOTH / SIDE_RIGHT / SIDE_LEFT / SIDE_OFF)
//   - default timing constants for a 50 MHz clock
//   - small helpers for counter sizing and switch decoding
package taillamp_pkg;

  typedef logic [1:0] taillamp_state_t;

  localparam taillamp_state_t IDLE   = 2'd0;
  localparam taillamp_state_t ARMING = 2'd1;
  localparam taillamp_state_t RUN    = 2'd2;

  localparam logic [1:0] SIDE_BOTH  = 2'b00;
  localparam logic [1:0] SIDE_RIGHT = 2'b01;
  localparam logic [1:0] SIDE_LEFT  = 2'b10;
  localparam logic [1:0] SIDE_OFF   = 2'b11;

  localparam int DEF_DEBOUNCE_CYCLES  = 1000000;    // 20 ms
  localparam int DEF_ARM_DELAY_CYCLES = 100000000;  // 2 s
  localparam int DEF_TICK_CYCLES      = 5000000;    // 0.1 s

  // Width of a counter that must hold 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Map synchronized {SW[9], SW[0]} onto the side_mode encoding.
  function automatic logic [1:0] side_decode(input logic sw_left, input logic sw_right);
    logic [1:0] mode;
    case ({sw_left, sw_right})
      2'b01:   mode = SIDE_RIGHT;
      2'b10:   mode = SIDE_LEFT;
      2'b11:   mode = SIDE_OFF;
      default: mode = SIDE_BOTH;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Two-flop synchronizer followed by a stability filter for one raw
// active-low key. The filtered level only moves once the synchronized
// level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//
// Configuration macro: TAILLAMP_DEBOUNCE_EN
//   defined   -> stability filter present
//   undefined -> key_deb follows the synchronized key directly
//
// Ports:
//   clk     in  system clock
//   RESET   in  asynchronous active-low reset
//   key     in  raw key level (asynchronous to clk)
//   key_deb out filtered key level (1 = released)
module key_debounce
  import taillamp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic RESET,
  input  logic key,
  output logic key_deb
);

  logic [1:0] sync_ff;
  logic       key_sync;

  // Metastability guard; resets to the released level.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], key};
  end

  assign key_sync = sync_ff[1];

`ifdef TAILLAMP_DEBOUNCE_EN
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             deb;

  // Count consecutive cycles of disagreement; any agreement (bounce back)
  // restarts the count from zero.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (key_sync != deb) begin
      if (cnt == CNT_LAST) begin
        deb <= key_sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign key_deb = deb;
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign key_deb    = key_sync;
`endif

endmodule

// File: rtl/taillamp_input_cond.sv
// taillamp_input_cond
// Conditions the START key and side switches for the tail-lamp animator
// and runs the IDLE -> ARMING -> RUN sequencer that gates the animation
// tick.
//
// Configuration macro: TAILLAMP_DEBOUNCE_EN (see key_debounce)
//
// Ports:
//   clk         in   50 MHz system clock
//   RESET       in   asynchronous active-low reset (KEY0)
//   START       in   raw active-low start key (KEY1)
//   SW[9:0]     in   raw slide switches, only SW[0] and SW[9] used
//   start_pulse out  one-cycle pulse per accepted start press
//   armed       out  high while in RUN
//   tick        out  one-cycle animation step strobe, RUN only
//   side_mode   out  00 both, 01 right, 10 left, 11 off
//   mode_change out  one-cycle pulse after side_mode changes
module taillamp_input_cond
  import taillamp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int ARM_DELAY_CYCLES = DEF_ARM_DELAY_CYCLES,
  parameter int TICK_CYCLES      = DEF_TICK_CYCLES
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       START,
  input  logic [9:0] SW,
  output logic       start_pulse,
  output logic       armed,
  output logic       tick,
  output logic [1:0] side_mode,
  output logic       mode_change
);

  localparam int ARM_W  = cnt_width(ARM_DELAY_CYCLES);
  localparam int TICK_W = cnt_width(TICK_CYCLES);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_DELAY_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  taillamp_state_t   state, state_next;
  logic [ARM_W-1:0]  arm_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              start_deb, start_deb_q;
  logic [1:0]        sw0_ff, sw9_ff;
  logic              arm_done, side_upd;
  logic [1:0]        side_next;
  logic              unused_sw;

  assign unused_sw = ^SW[8:1];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_key (
    .clk    (clk),
    .RESET  (RESET),
    .key    (START),
    .key_deb(start_deb)
  );

  // Accepted press = falling edge of the filtered key, registered so the
  // pulse lands in the cycle after the filtered level falls.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      start_deb_q <= 1'b1;
      start_pulse <= 1'b0;
    end else begin
      start_deb_q <= start_deb;
      start_pulse <= start_deb_q & ~start_deb;
    end
  end

  // Switches are levels, not keys, so they only need synchronizing.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      sw0_ff <= 2'b00;
      sw9_ff <= 2'b00;
    end else begin
      sw0_ff <= {sw0_ff[0], SW[0]};
      sw9_ff <= {sw9_ff[0], SW[9]};
    end
  end

  assign arm_done  = (arm_cnt == ARM_LAST);
  assign armed     = (state == RUN);
  // A press in the same cycle wins over a tick, so the exit cycle is silent.
  assign tick      = (state == RUN) && (tick_cnt == '0) && !start_pulse;
  assign side_upd  = (state != RUN) || tick;
  assign side_next = side_decode(sw9_ff[1], sw0_ff[1]);

  // Next-state logic; a press always has priority over arm expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_pulse) state_next = ARMING;
      ARMING:  if (start_pulse) state_next = IDLE;
               else if (arm_done) state_next = RUN;
      RUN:     if (start_pulse) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and counters; counters are held at zero outside their state so
  // every entry into ARMING or RUN starts a full interval.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ARMING && !start_pulse && !arm_done) arm_cnt <= arm_cnt + 1'b1;
      else                                               arm_cnt <= '0;
      if (state == RUN && !start_pulse)
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      else
        tick_cnt <= '0;
    end
  end

  // side_mode follows the switches except in RUN, where it is frozen
  // between ticks so a frame never tears; mode_change flags the update.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      side_mode   <= SIDE_BOTH;
      mode_change <= 1'b0;
    end else if (side_upd) begin
      side_mode   <= side_next;
      mode_change <= (side_next != side_mode);
    end else begin
      mode_change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_taillamp_input_cond.sv
// tb_taillamp_input_cond
// Directed self-checking bench for taillamp_input_cond with
// DEBOUNCE_CYCLES=4, ARM_DELAY_CYCLES=20, TICK_CYCLES=10.
// Press latency follows TAILLAMP_DEBOUNCE_EN: 2 sync + filter + 1 pulse.
module tb_taillamp_input_cond;
  import taillamp_pkg::*;

  localparam int DEB = 4;
  localparam int ARM = 20;
  localparam int TCK = 10;
`ifdef TAILLAMP_DEBOUNCE_EN
  localparam int DEB_LAT = DEB;
  localparam bit FILT    = 1'b1;
`else
  localparam int DEB_LAT = 0;
  localparam bit FILT    = 1'b0;
`endif
  localparam int PRESS_LAT = 2 + DEB_LAT + 1;
  localparam int DRIVE_R   = 40 - PRESS_LAT;

  logic       clk = 1'b0;
  logic       RESET;
  logic       START;
  logic [9:0] SW;
  logic       start_pulse, armed, tick, mode_change;
  logic [1:0] side_mode;

  int n_cmp = 0;
  int n_err = 0;

  taillamp_input_cond #(
    .DEBOUNCE_CYCLES (DEB),
    .ARM_DELAY_CYCLES(ARM),
    .TICK_CYCLES     (TCK)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .START      (START),
    .SW         (SW),
    .start_pulse(start_pulse),
    .armed      (armed),
    .tick       (tick),
    .side_mode  (side_mode),
    .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " start_pulse"}, 32'(start_pulse), 0);
    check({tag, " armed"},       32'(armed), 0);
    check({tag, " tick"},        32'(tick), 0);
    check({tag, " side_mode"},   32'(side_mode), 32'(SIDE_BOTH));
    check({tag, " mode_change"}, 32'(mode_change), 0);
    check({tag, " state"},       32'(dut.state), 32'(IDLE));
  endtask

  int pulse_cnt, pulse_a, pulse_b, run_at, armed_hits, tick_hits;
  logic tick_first;
  taillamp_state_t st_a, st_b;

  initial begin
    RESET = 1'b0;
    START = 1'b1;
    SW    = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    RESET = 1'b1;
    repeat (3) step();
    check_idle_outputs("post_reset");

    // Clean press: one pulse, ARMING, RUN after 20 cycles with a tick.
    START = 1'b0;
    pulse_cnt = 0; pulse_a = -1; run_at = -1; tick_first = 1'b0;
    for (int k = 1; k <= PRESS_LAT + 21; k++) begin
      step();
      if (start_pulse) begin pulse_cnt++; pulse_a = k; end
      if (armed && run_at < 0) begin run_at = k; tick_first = tick; end
      if (k == PRESS_LAT + 1) st_a = dut.state;
      if (k == 10) START = 1'b1;
    end
    check("press_pulse_count", 32'(pulse_cnt), 1);
    check("press_pulse_cycle", 32'(pulse_a), 32'(PRESS_LAT));
    check("press_enters_arming", 32'(st_a), 32'(ARMING));
    check("run_entry_cycle", 32'(run_at), 32'(PRESS_LAT + 21));
    check("run_entry_tick", 32'(tick_first), 1);

    // RUN: ticks every 10, side_mode frozen until tick, stop on a tick cycle.
    for (int r = 0; r < 50; r++) begin
      if (r > 0) step();
      check($sformatf("run_tick_r%0d", r), 32'(tick), 32'((r % 10 == 0) && (r < 40)));
      check($sformatf("run_armed_r%0d", r), 32'(armed), 32'(r <= 40));
      check($sformatf("run_side_r%0d", r), 32'(side_mode), 32'((r >= 11) ? SIDE_RIGHT : SIDE_BOTH));
      check($sformatf("run_mchg_r%0d", r), 32'(mode_change), 32'(r == 11));
      check($sformatf("run_spulse_r%0d", r), 32'(start_pulse), 32'(r == 40));
      if (r == 41) check("stop_to_idle", 32'(dut.state), 32'(IDLE));
      if (r == 3) SW[0] = 1'b1;
      if (r == DRIVE_R) START = 1'b0;
      if (r == DRIVE_R + 10) START = 1'b1;
    end
    repeat (6) step();

    // Bouncing key: toggles every 2 cycles.
    pulse_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      START = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (start_pulse) pulse_cnt++;
    end
    START = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (start_pulse) pulse_cnt++;
    end
    check("bounce_pulses", 32'(pulse_cnt), FILT ? 0 : 5);
`ifdef TAILLAMP_DEBOUNCE_EN
    check("bounce_state_idle", 32'(dut.state), 32'(IDLE));
    check("bounce_not_armed", 32'(armed), 0);
`endif

    RESET = 1'b0;
    step();
    RESET = 1'b1;
    repeat (3) step();

    // Cancel press landing exactly on arm expiry.
    START = 1'b0;
    pulse_cnt = 0; pulse_a = -1; pulse_b = -1; armed_hits = 0; tick_hits = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (start_pulse) begin
        pulse_cnt++;
        if (pulse_a < 0) pulse_a = c;
        pulse_b = c;
      end
      if (armed) armed_hits++;
      if (tick) tick_hits++;
      if (c == PRESS_LAT + 20) st_a = dut.state;
      if (c == PRESS_LAT + 21) st_b = dut.state;
      if (c == 10) START = 1'b1;
      if (c == 20) START = 1'b0;
      if (c == 30) START = 1'b1;
    end
    check("cancel_pulse_count", 32'(pulse_cnt), 2);
    check("cancel_first_pulse", 32'(pulse_a), 32'(PRESS_LAT));
    check("cancel_second_pulse", 32'(pulse_b), 32'(PRESS_LAT + 20));
    check("cancel_last_arming", 32'(st_a), 32'(ARMING));
    check("cancel_to_idle", 32'(st_b), 32'(IDLE));
    check("cancel_never_armed", 32'(armed_hits), 0);
    check("cancel_no_tick", 32'(tick_hits), 0);

    // Side tracking in IDLE: 2 sync cycles plus one register stage.
    SW = 10'h201;
    step();
    step();
    check("idle_side_before", 32'(side_mode), 32'(SIDE_RIGHT));
    step();
    check("idle_side_off", 32'(side_mode), 32'(SIDE_OFF));
    check("idle_mchg_pulse", 32'(mode_change), 1);
    step();
    check("idle_mchg_clear", 32'(mode_change), 0);

    // Asynchronous reset mid-RUN, then a full re-arm.
    START = 1'b0;
    for (int k = 1; k <= PRESS_LAT + 25; k++) begin
      step();
      if (k == 10) START = 1'b1;
    end
    check("prereset_armed", 32'(armed), 1);
    check("prereset_side", 32'(side_mode), 32'(SIDE_OFF));
    RESET = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    step();
    RESET = 1'b1;
    START = 1'b0;
    run_at = -1;
    for (int k = 1; k <= PRESS_LAT + 25; k++) begin
      step();
      if (armed && run_at < 0) run_at = k;
      if (k == PRESS_LAT + 1) st_a = dut.state;
      if (k == 10) START = 1'b1;
    end
    check("rearm_arming", 32'(st_a), 32'(ARMING));
    check("rearm_run_cycle", 32'(run_at), 32'(PRESS_LAT + 21));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
